// File: rtl/pipe_stage_pkg.sv
// Shared definitions for the pipeline-stage skid register.
// Occupancy encoding is exported directly on the Occupancy port.
package pipe_stage_pkg;

    typedef logic [1:0] stage_state_t;

    localparam stage_state_t ST_EMPTY = 2'd0;
    localparam stage_state_t ST_ONE   = 2'd1;
    localparam stage_state_t ST_TWO   = 2'd2;

endpackage

// File: rtl/pipe_stage_skid_reg.sv
// Pipeline-stage register with valid/ready handshake and a 2-entry skid.
// Adv = ClockEnable & Tick gates every update except Reset.
module pipe_stage_skid_reg
    import pipe_stage_pkg::*;
#(
    parameter int                    NrOfBits      = 32,
    parameter logic [NrOfBits-1:0]   ResetValue    = '0,
    parameter logic [NrOfBits-1:0]   PresetValue   = '1,
    parameter int                    NrOfCountBits = 16
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     ClockEnable,
    input  logic                     Tick,
    input  logic                     Flush,
    input  logic                     Preset,
    input  logic                     InValid,
    input  logic [NrOfBits-1:0]      D,
    output logic                     InReady,
    output logic                     OutValid,
    input  logic                     OutReady,
    output logic [NrOfBits-1:0]      Q,
    output logic [1:0]               Occupancy,
    output logic [NrOfCountBits-1:0] StallCount
);

    stage_state_t             state;
    logic [NrOfBits-1:0]      main_data;
    logic [NrOfBits-1:0]      skid_data;
    logic [NrOfCountBits-1:0] stall_cnt;

    logic adv;
    logic ctrl;
    logic acc;
    logic drn;
    logic stall;

    assign adv  = ClockEnable & Tick;
    assign ctrl = Flush | Preset;

    assign InReady  = adv & (state != ST_TWO) & ~ctrl;
    assign OutValid = adv & (state != ST_EMPTY) & ~ctrl;

    assign acc   = InValid & InReady;
    assign drn   = OutValid & OutReady;
    assign stall = adv & (state != ST_EMPTY) & ~OutReady & ~ctrl;

    assign Q          = main_data;
    assign Occupancy  = state;
    assign StallCount = stall_cnt;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= ST_EMPTY;
            main_data <= ResetValue;
            skid_data <= ResetValue;
        end else if (adv) begin
            if (Flush) begin
                state <= ST_EMPTY;
            end else if (Preset) begin
                state     <= ST_ONE;
                main_data <= PresetValue;
            end else begin
                unique case (state)
                    ST_EMPTY: begin
                        if (acc) begin
                            state     <= ST_ONE;
                            main_data <= D;
                        end
                    end
                    ST_ONE: begin
                        if (acc && drn) begin
                            main_data <= D;
                        end else if (acc) begin
                            state     <= ST_TWO;
                            skid_data <= D;
                        end else if (drn) begin
                            state <= ST_EMPTY;
                        end
                    end
                    ST_TWO: begin
                        if (drn) begin
                            state     <= ST_ONE;
                            main_data <= skid_data;
                        end
                    end
                    default: state <= ST_EMPTY;
                endcase
            end
        end
    end

    // Saturating profile counter: sticks at all ones until Reset.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Directed testbench for pipe_stage_skid_reg.
// Inputs change 1 time unit after each rising edge.
module tb_pipe_stage_skid_reg;

    localparam int W  = 32;
    localparam int CB = 4;

    logic          Clock = 1'b0;
    logic          Reset;
    logic          ClockEnable;
    logic          Tick;
    logic          Flush;
    logic          Preset;
    logic          InValid;
    logic [W-1:0]  D;
    logic          InReady;
    logic          OutValid;
    logic          OutReady;
    logic [W-1:0]  Q;
    logic [1:0]    Occupancy;
    logic [CB-1:0] StallCount;

    int checks = 0;
    int errors = 0;

    pipe_stage_skid_reg #(
        .NrOfBits     (W),
        .ResetValue   (32'h0),
        .PresetValue  (32'hFFFF_FFFF),
        .NrOfCountBits(CB)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .ClockEnable(ClockEnable),
        .Tick       (Tick),
        .Flush      (Flush),
        .Preset     (Preset),
        .InValid    (InValid),
        .D          (D),
        .InReady    (InReady),
        .OutValid   (OutValid),
        .OutReady   (OutReady),
        .Q          (Q),
        .Occupancy  (Occupancy),
        .StallCount (StallCount)
    );

    always #5 Clock = ~Clock;

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1; ClockEnable = 0; Tick = 0; Flush = 0; Preset = 0;
        InValid = 0; D = '0; OutReady = 0;
        step(); step();
        checks++;
        if (Q !== 32'h0 || Occupancy !== 2'd0 || StallCount !== 4'd0) begin
            errors++;
            $display("FAIL reset_state: Q=%h occ=%0d stall=%0d want 0/0/0",
                     Q, Occupancy, StallCount);
        end
        checks++;
        if (InReady !== 1'b0 || OutValid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs: InReady=%b OutValid=%b want 0/0",
                     InReady, OutValid);
        end
        Reset = 0;
        step();
    endtask

    task automatic test_stream();
        ClockEnable = 1; Tick = 1; OutReady = 1; InValid = 1; D = 1;
        #1;
        checks++;
        if (InReady !== 1'b1 || OutValid !== 1'b0) begin
            errors++;
            $display("FAIL stream_start: InReady=%b OutValid=%b want 1/0",
                     InReady, OutValid);
        end
        for (int i = 1; i <= 4; i++) begin
            step();
            if (i < 4) D = 32'(i + 1);
            else InValid = 0;
            #1;
            checks++;
            if (Q !== 32'(i) || OutValid !== 1'b1 || Occupancy !== 2'd1 ||
                (i < 4 && InReady !== 1'b1)) begin
                errors++;
                $display("FAIL stream_q%0d: Q=%0d v=%b occ=%0d rdy=%b want %0d/1/1/1",
                         i, Q, OutValid, Occupancy, InReady, i);
            end
        end
        step();
        checks++;
        if (Occupancy !== 2'd0 || OutValid !== 1'b0 || StallCount !== 4'd0) begin
            errors++;
            $display("FAIL stream_end: occ=%0d v=%b stall=%0d want 0/0/0",
                     Occupancy, OutValid, StallCount);
        end
    endtask

    task automatic test_fill_drain();
        OutReady = 0; InValid = 1; D = 32'hA;
        step();
        D = 32'hB;
        #1;
        checks++;
        if (InReady !== 1'b1 || Q !== 32'hA || StallCount !== 4'd0) begin
            errors++;
            $display("FAIL fill_one: rdy=%b Q=%h stall=%0d want 1/a/0",
                     InReady, Q, StallCount);
        end
        step();
        InValid = 0;
        #1;
        checks++;
        if (Occupancy !== 2'd2 || InReady !== 1'b0 || Q !== 32'hA ||
            StallCount !== 4'd1) begin
            errors++;
            $display("FAIL fill_two: occ=%0d rdy=%b Q=%h stall=%0d want 2/0/a/1",
                     Occupancy, InReady, Q, StallCount);
        end
        step();
        checks++;
        if (StallCount !== 4'd2) begin
            errors++;
            $display("FAIL fill_stall: stall=%0d want 2", StallCount);
        end
        OutReady = 1;
        #1;
        checks++;
        if (OutValid !== 1'b1 || Q !== 32'hA) begin
            errors++;
            $display("FAIL drain_a: v=%b Q=%h want 1/a", OutValid, Q);
        end
        step();
        checks++;
        if (Occupancy !== 2'd1 || Q !== 32'hB || StallCount !== 4'd2) begin
            errors++;
            $display("FAIL drain_b: occ=%0d Q=%h stall=%0d want 1/b/2",
                     Occupancy, Q, StallCount);
        end
        step();
        checks++;
        if (Occupancy !== 2'd0 || OutValid !== 1'b0) begin
            errors++;
            $display("FAIL drain_end: occ=%0d v=%b want 0/0", Occupancy, OutValid);
        end
    endtask

    task automatic test_tick_hold();
        OutReady = 0; InValid = 1; D = 32'hC;
        step();
        D = 32'hD;
        step();
        InValid = 0; Tick = 0; OutReady = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (Occupancy !== 2'd2 || Q !== 32'hC || StallCount !== 4'd3 ||
                InReady !== 1'b0 || OutValid !== 1'b0) begin
                errors++;
                $display("FAIL tick_hold%0d: occ=%0d Q=%h stall=%0d rdy=%b v=%b want 2/c/3/0/0",
                         i, Occupancy, Q, StallCount, InReady, OutValid);
            end
        end
        Tick = 1;
    endtask

    task automatic test_flush_preset();
        OutReady = 0; Flush = 1; InValid = 1; D = 32'h55;
        #1;
        checks++;
        if (InReady !== 1'b0 || OutValid !== 1'b0) begin
            errors++;
            $display("FAIL flush_hs: rdy=%b v=%b want 0/0", InReady, OutValid);
        end
        step();
        Flush = 0; InValid = 0;
        #1;
        checks++;
        if (Occupancy !== 2'd0 || OutValid !== 1'b0 || Q !== 32'hC ||
            StallCount !== 4'd3) begin
            errors++;
            $display("FAIL flush_state: occ=%0d v=%b Q=%h stall=%0d want 0/0/c/3",
                     Occupancy, OutValid, Q, StallCount);
        end
        Preset = 1;
        step();
        Preset = 0;
        #1;
        checks++;
        if (Occupancy !== 2'd1 || Q !== 32'hFFFF_FFFF || OutValid !== 1'b1) begin
            errors++;
            $display("FAIL preset: occ=%0d Q=%h v=%b want 1/ffffffff/1",
                     Occupancy, Q, OutValid);
        end
    endtask

    task automatic test_stall_saturate();
        OutReady = 0; InValid = 0;
        for (int i = 0; i < 5; i++) step();
        checks++;
        if (StallCount !== 4'd8) begin
            errors++;
            $display("FAIL stall_count: stall=%0d want 8", StallCount);
        end
        for (int i = 0; i < 15; i++) step();
        checks++;
        if (StallCount !== 4'd15) begin
            errors++;
            $display("FAIL stall_sat: stall=%0d want 15", StallCount);
        end
        step(); step();
        checks++;
        if (StallCount !== 4'd15 || Occupancy !== 2'd1) begin
            errors++;
            $display("FAIL stall_hold: stall=%0d occ=%0d want 15/1",
                     StallCount, Occupancy);
        end
        Reset = 1;
        step();
        Reset = 0;
        checks++;
        if (StallCount !== 4'd0 || Occupancy !== 2'd0) begin
            errors++;
            $display("FAIL stall_clr: stall=%0d occ=%0d want 0/0",
                     StallCount, Occupancy);
        end
    endtask

    task automatic test_reset_mid();
        OutReady = 0; InValid = 1; D = 32'h1;
        step();
        D = 32'h2;
        step();
        InValid = 0;
        checks++;
        if (Occupancy !== 2'd2 || StallCount !== 4'd1) begin
            errors++;
            $display("FAIL mid_fill: occ=%0d stall=%0d want 2/1",
                     Occupancy, StallCount);
        end
        Reset = 1; Flush = 1; Preset = 1;
        step();
        Reset = 0; Flush = 0; Preset = 0;
        #1;
        checks++;
        if (Occupancy !== 2'd0 || Q !== 32'h0 || StallCount !== 4'd0 ||
            OutValid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: occ=%0d Q=%h stall=%0d v=%b want 0/0/0/0",
                     Occupancy, Q, StallCount, OutValid);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_fill_drain();
        test_tick_hold();
        test_flush_preset();
        test_stall_saturate();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: sim time exceeded limit");
        $fatal(1, "timeout");
    end

endmodule
